ahb_slave_port_arbiter: RTL and testbench

//  Request-direction counterpart of the per-master response mux in the AHB_Gen interconnect. One instance sits in front of each slave port.
//  - Arbitrates among CHANNEL_NUM masters whose decoders address this slave.
//  - Tracks address-phase and data-phase ownership separately.
//  - Drives the slave with control from the address-phase owner and HWDATA from the data-phase owner.
//  - Exports data_sel so the response mux can route HRDATA/HRESP/HREADY back to the right master.

---
 rtl/ahb_slave_port_arbiter_pkg.sv | 31 +++
 rtl/ahb_rr_picker.sv | 31 +++
 rtl/ahb_slave_port_arbiter.sv | 99 +++++++++
 tb/tb_ahb_slave_port_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ahb_slave_port_arbiter_pkg.sv
// rtl/ahb_slave_port_arbiter_pkg.sv - AHB request payload layout and transfer-type encoding
package ahb_slave_port_arbiter_pkg;

    localparam int HADDR_HI      = 77;
    localparam int HADDR_LO      = 46;
    localparam int HWDATA_HI     = 45;
    localparam int HWDATA_LO     = 14;
    localparam int HTRANS_HI     = 13;
    localparam int HTRANS_LO     = 12;
    localparam int HBURST_HI     = 11;
    localparam int HBURST_LO     = 9;
    localparam int HSIZE_HI      = 8;
    localparam int HSIZE_LO      = 6;
    localparam int HPROT_HI      = 5;
    localparam int HPROT_LO      = 2;
    localparam int HWRITE_BIT    = 1;
    localparam int HMASTLOCK_BIT = 0;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    // Only NONSEQ and SEQ beats are followed by a data phase.
    function automatic logic carries_data(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// rtl/ahb_rr_picker.sv - combinational round-robin / fixed-priority winner picker
module ahb_rr_picker #(
    parameter int N      = 4,
    parameter bit ARB_RR = 1'b1,
    localparam int IW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          valid
);

    always_comb begin
        int p;
        p     = 0;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        // Round-robin starts one past the last winner; fixed priority always starts at 0.
        for (int k = 0; k < N; k++) begin
            p = ARB_RR ? ((int'(ptr) + 1 + k) % N) : k;
            if (!valid && req[p]) begin
                valid    = 1'b1;
                grant[p] = 1'b1;
                idx      = IW'(p);
            end
        end
    end

endmodule

// File: rtl/ahb_slave_port_arbiter.sv
// rtl/ahb_slave_port_arbiter.sv - per-slave request arbiter with split address/data phase ownership
module ahb_slave_port_arbiter
    import ahb_slave_port_arbiter_pkg::*;
#(
    parameter int CHANNEL_NUM = 4,
    parameter int PAY_LOAD    = 78,
    parameter bit ARB_RR      = 1'b1
) (
    input  logic                                   HCLK,
    input  logic                                   HRESETn,
    input  logic [CHANNEL_NUM-1:0]                 req,
    input  logic [CHANNEL_NUM-1:0][PAY_LOAD-1:0]   payload_in,
    input  logic                                   hready_in,
    output logic [PAY_LOAD-1:0]                    payload_out,
    output logic [CHANNEL_NUM-1:0]                 addr_sel,
    output logic [CHANNEL_NUM-1:0]                 data_sel
);

    localparam int IW = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;

    logic [CHANNEL_NUM-1:0] addr_sel_q, addr_sel_d;
    logic [CHANNEL_NUM-1:0] data_sel_q, data_sel_d;
    logic [IW-1:0]          ptr_q, ptr_d;

    logic [PAY_LOAD-1:0]    addr_pl, data_pl, hwdata_mask;
    logic [1:0]             owner_htrans;
    logic                   owner_req, owner_lock, hold;

    logic [CHANNEL_NUM-1:0] win_grant;
    logic [IW-1:0]          win_idx;
    logic                   win_valid;

    ahb_rr_picker #(
        .N      (CHANNEL_NUM),
        .ARB_RR (ARB_RR)
    ) u_picker (
        .req   (req),
        .ptr   (ptr_q),
        .grant (win_grant),
        .idx   (win_idx),
        .valid (win_valid)
    );

    // Selects are one-hot or zero, so an AND-OR mux suffices.
    always_comb begin
        addr_pl = '0;
        data_pl = '0;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            addr_pl = addr_pl | ({PAY_LOAD{addr_sel_q[i]}} & payload_in[i]);
            data_pl = data_pl | ({PAY_LOAD{data_sel_q[i]}} & payload_in[i]);
        end
    end

    always_comb begin
        hwdata_mask                      = '0;
        hwdata_mask[HWDATA_HI:HWDATA_LO] = '1;
    end

    assign owner_htrans = addr_pl[HTRANS_HI:HTRANS_LO];
    assign owner_lock   = addr_pl[HMASTLOCK_BIT];
    assign owner_req    = |(addr_sel_q & req);
    assign hold         = owner_req & ((owner_htrans == HTRANS_SEQ) ||
                                       (owner_htrans == HTRANS_BUSY) || owner_lock);

    always_comb begin
        addr_sel_d = addr_sel_q;
        data_sel_d = data_sel_q;
        ptr_d      = ptr_q;
        if (hready_in) begin
            data_sel_d = carries_data(owner_htrans) ? addr_sel_q : '0;
            if (!hold) begin
                addr_sel_d = win_grant;
                if (win_valid) begin
                    ptr_d = win_idx;
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_sel_q <= '0;
            data_sel_q <= '0;
            ptr_q      <= IW'(CHANNEL_NUM - 1);
        end else begin
            addr_sel_q <= addr_sel_d;
            data_sel_q <= data_sel_d;
            ptr_q      <= ptr_d;
        end
    end

    assign addr_sel    = addr_sel_q;
    assign data_sel    = data_sel_q;
    assign payload_out = (addr_pl & ~hwdata_mask) | (data_pl & hwdata_mask);

    a_addr_onehot0: assert property (@(posedge HCLK) disable iff (!HRESETn) $onehot0(addr_sel_q));
    a_data_onehot0: assert property (@(posedge HCLK) disable iff (!HRESETn) $onehot0(data_sel_q));

endmodule

// File: tb/tb_ahb_slave_port_arbiter.sv
// tb/tb_ahb_slave_port_arbiter.sv - vector table and scoreboard bench for ahb_slave_port_arbiter
module tb_ahb_slave_port_arbiter;
    import ahb_slave_port_arbiter_pkg::*;

    typedef struct {
        logic [3:0] req;
        logic [7:0] ht;
        logic [3:0] lk;
        logic       hr;
        logic [3:0] ea;
        logic [3:0] ed;
    } vec_t;

    logic             HCLK = 1'b0;
    logic             HRESETn;
    logic [3:0]       req;
    logic [3:0][77:0] payload_in;
    logic             hready_in;
    logic [77:0]      payload_out, fp_payload_out;
    logic [3:0]       addr_sel, data_sel, fp_addr_sel, fp_data_sel;

    int total = 0;
    int bad   = 0;
    string tag;

    vec_t main_tbl[15];
    vec_t lock_tbl[4];
    vec_t rr_tbl[5];
    vec_t exp_q[$];

    always #5 HCLK = ~HCLK;

    ahb_slave_port_arbiter #(.CHANNEL_NUM(4), .PAY_LOAD(78), .ARB_RR(1'b1)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .req(req), .payload_in(payload_in),
        .hready_in(hready_in), .payload_out(payload_out),
        .addr_sel(addr_sel), .data_sel(data_sel)
    );

    ahb_slave_port_arbiter #(.CHANNEL_NUM(4), .PAY_LOAD(78), .ARB_RR(1'b0)) dut_fp (
        .HCLK(HCLK), .HRESETn(HRESETn), .req(req), .payload_in(payload_in),
        .hready_in(hready_in), .payload_out(fp_payload_out),
        .addr_sel(fp_addr_sel), .data_sel(fp_data_sel)
    );

    function automatic logic [77:0] mk(input int m, input logic [1:0] t, input logic l);
        logic [77:0] p;
        p = '0;
        p[HADDR_HI:HADDR_LO]   = 32'h4000_0000 + 32'(m) * 32'h100;
        p[HWDATA_HI:HWDATA_LO] = 32'hD000_0000 | 32'(m);
        p[HTRANS_HI:HTRANS_LO] = t;
        p[HBURST_HI:HBURST_LO] = 3'(m);
        p[HSIZE_HI:HSIZE_LO]   = 3'd2;
        p[HPROT_HI:HPROT_LO]   = 4'h3;
        p[HWRITE_BIT]          = 1'b1;
        p[HMASTLOCK_BIT]       = l;
        return p;
    endfunction

    function automatic int idx_of(input logic [3:0] s);
        for (int i = 0; i < 4; i++) if (s[i]) return i;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [77:0] act, input logic [77:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s %s: got %0h want %0h", tag, name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        req       = v.req;
        hready_in = v.hr;
        for (int i = 0; i < 4; i++) payload_in[i] = mk(i, v.ht[2*i +: 2], v.lk[i]);
    endtask

    task automatic check_front();
        vec_t        e;
        int          a, d;
        logic [77:0] ep, tmp;
        e  = exp_q.pop_front();
        a  = idx_of(e.ea);
        d  = idx_of(e.ed);
        ep = '0;
        if (a >= 0) begin
            ep = mk(a, e.ht[2*a +: 2], e.lk[a]);
            ep[HWDATA_HI:HWDATA_LO] = '0;
        end
        if (d >= 0) begin
            tmp = mk(d, 2'b00, 1'b0);
            ep[HWDATA_HI:HWDATA_LO] = tmp[HWDATA_HI:HWDATA_LO];
        end
        chk("addr_sel", 78'(addr_sel), 78'(e.ea));
        chk("data_sel", 78'(data_sel), 78'(e.ed));
        chk("payload_out", payload_out, ep);
    endtask

    task automatic apply(input vec_t v);
        drive(v);
        exp_q.push_back(v);
        @(posedge HCLK);
        @(negedge HCLK);
        check_front();
    endtask

    task automatic pulse_reset();
        vec_t z;
        z = '{4'b0, 8'h00, 4'h0, 1'b1, 4'b0, 4'b0};
        @(negedge HCLK);
        HRESETn = 1'b0;
        drive(z);
        @(negedge HCLK);
        HRESETn = 1'b1;
    endtask

    initial begin
        vec_t v;
        // single master, burst with wait states, handover
        main_tbl[0]  = '{4'b0100, 8'h20, 4'h0, 1'b1, 4'b0100, 4'b0000};
        main_tbl[1]  = '{4'b0100, 8'h20, 4'h0, 1'b1, 4'b0100, 4'b0100};
        main_tbl[2]  = '{4'b0000, 8'h00, 4'h0, 1'b1, 4'b0000, 4'b0000};
        main_tbl[3]  = '{4'b0000, 8'h00, 4'h0, 1'b1, 4'b0000, 4'b0000};
        main_tbl[4]  = '{4'b0010, 8'h08, 4'h0, 1'b1, 4'b0010, 4'b0000};
        main_tbl[5]  = '{4'b0010, 8'h08, 4'h0, 1'b1, 4'b0010, 4'b0010};
        main_tbl[6]  = '{4'b1010, 8'h8C, 4'h0, 1'b1, 4'b0010, 4'b0010};
        main_tbl[7]  = '{4'b1010, 8'h8C, 4'h0, 1'b0, 4'b0010, 4'b0010};
        main_tbl[8]  = '{4'b1010, 8'h8C, 4'h0, 1'b0, 4'b0010, 4'b0010};
        main_tbl[9]  = '{4'b1010, 8'h8C, 4'h0, 1'b0, 4'b0010, 4'b0010};
        main_tbl[10] = '{4'b1010, 8'h8C, 4'h0, 1'b1, 4'b0010, 4'b0010};
        main_tbl[11] = '{4'b1010, 8'h8C, 4'h0, 1'b1, 4'b0010, 4'b0010};
        main_tbl[12] = '{4'b1000, 8'h80, 4'h0, 1'b1, 4'b1000, 4'b0000};
        main_tbl[13] = '{4'b1000, 8'h80, 4'h0, 1'b1, 4'b1000, 4'b1000};
        main_tbl[14] = '{4'b0000, 8'h00, 4'h0, 1'b1, 4'b0000, 4'b0000};
        // four masters, all single NONSEQ
        rr_tbl[0] = '{4'b1111, 8'hAA, 4'h0, 1'b1, 4'b0001, 4'b0000};
        rr_tbl[1] = '{4'b1111, 8'hAA, 4'h0, 1'b1, 4'b0010, 4'b0001};
        rr_tbl[2] = '{4'b1111, 8'hAA, 4'h0, 1'b1, 4'b0100, 4'b0010};
        rr_tbl[3] = '{4'b1111, 8'hAA, 4'h0, 1'b1, 4'b1000, 4'b0100};
        rr_tbl[4] = '{4'b1111, 8'hAA, 4'h0, 1'b1, 4'b0001, 4'b1000};
        // master 0 locked, idles while master 3 waits
        lock_tbl[0] = '{4'b0001, 8'h02, 4'h1, 1'b1, 4'b0001, 4'b0000};
        lock_tbl[1] = '{4'b1001, 8'h80, 4'h1, 1'b1, 4'b0001, 4'b0000};
        lock_tbl[2] = '{4'b1001, 8'h80, 4'h1, 1'b1, 4'b0001, 4'b0000};
        lock_tbl[3] = '{4'b1001, 8'h82, 4'h1, 1'b1, 4'b0001, 4'b0001};

        tag     = "reset";
        HRESETn = 1'b0;
        drive('{4'b1111, 8'hAA, 4'h0, 1'b1, 4'b0, 4'b0});
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        chk("addr_sel", 78'(addr_sel), 78'h0);
        chk("data_sel", 78'(data_sel), 78'h0);
        chk("payload_out", payload_out, 78'h0);
        chk("fp_addr_sel", 78'(fp_addr_sel), 78'h0);
        HRESETn = 1'b1;
        drive('{4'b0, 8'h00, 4'h0, 1'b1, 4'b0, 4'b0});

        for (int i = 0; i < 15; i++) begin
            tag = $sformatf("main[%0d]", i);
            apply(main_tbl[i]);
        end

        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            tag = $sformatf("rr[%0d]", i);
            apply(rr_tbl[i]);
            chk("fp_addr_sel", 78'(fp_addr_sel), 78'h1);
        end

        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            tag = $sformatf("lock[%0d]", i);
            apply(lock_tbl[i]);
        end

        tag = "async_reset";
        drive('{4'b1001, 8'h83, 4'h1, 1'b1, 4'b0, 4'b0});
        @(posedge HCLK);
        #2;
        chk("addr_sel_before", 78'(addr_sel), 78'h1);
        chk("data_sel_before", 78'(data_sel), 78'h1);
        HRESETn = 1'b0;
        #1;
        chk("addr_sel", 78'(addr_sel), 78'h0);
        chk("data_sel", 78'(data_sel), 78'h0);
        chk("payload_out", payload_out, 78'h0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        tag = "after_reset";
        v = '{4'b1001, 8'h82, 4'h0, 1'b1, 4'b0001, 4'b0000};
        apply(v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
